// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-cache line loader.
// Default geometry: 64-bit host words packed into 512-bit lines of 16-bit instructions.
package fetch_pkg;

  localparam int PCW_DEF        = 32;
  localparam int INSTRW_DEF     = 16;
  localparam int INW_DEF        = 512;
  localparam int HOSTW_DEF      = 64;
  localparam int WORDS_PER_LINE = INW_DEF / HOSTW_DEF;
  localparam int LINE_STEP      = INW_DEF / INSTRW_DEF;
  localparam int WCNT_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_line_loader_if.sv
// Host word stream plus cache line-write port, bundled for the loader.
// slave = loader side, master = host/cache side.
interface instr_line_loader_if #(
  parameter int PCW   = 32,
  parameter int INW   = 512,
  parameter int HOSTW = 64
);

  logic             host_valid;
  logic [HOSTW-1:0] host_data;
  logic             host_ready;
  logic             line_write_en;
  logic [INW-1:0]   line_data;
  logic [PCW-1:0]   line_addr;

  modport slave (
    input  host_valid, host_data,
    output host_ready, line_write_en, line_data, line_addr
  );

  modport master (
    output host_valid, host_data,
    input  host_ready, line_write_en, line_data, line_addr
  );

endinterface

// File: rtl/line_packer.sv
// Word counter plus line register: accepted words land least-significant first.
// last_word flags that the next accepted word completes the line.
module line_packer #(
  parameter int HOSTW = 64,
  parameter int WORDS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [HOSTW-1:0]       word_in,
  output logic [WORDS*HOSTW-1:0] line_out,
  output logic                   last_word
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WORDS*HOSTW-1:0] line_q, line_d;

  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      line_d[cnt_q*HOSTW +: HOSTW] = word_in;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign line_out  = line_q;
  assign last_word = (cnt_q == CW'(WORDS - 1));

endmodule

// File: rtl/instr_line_loader.sv
// Streams a program image into the instruction cache one line at a time,
// stalling fetch (busy) until every requested line has been written.
module instr_line_loader
  import fetch_pkg::*;
#(
  parameter int PCW    = PCW_DEF,
  parameter int INSTRW = INSTRW_DEF,
  parameter int INW    = INW_DEF,
  parameter int HOSTW  = HOSTW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [PCW-1:0] base_addr,
  input  logic [15:0]    num_lines,
  output logic           busy,
  output logic           done,
  instr_line_loader_if.slave bus
);

  localparam int WORDS = INW / HOSTW;
  localparam int STEP  = INW / INSTRW;

  state_e         state_q, state_d;
  logic [PCW-1:0] addr_q, addr_d;
  logic [PCW-1:0] line_addr_q, line_addr_d;
  logic [15:0]    rem_q, rem_d;
  logic           clear, accept, last_word;

  // Handshake and strobes decode from state only, so host_valid never reaches host_ready.
  assign bus.host_ready    = (state_q == FILL);
  assign bus.line_write_en = (state_q == WRITE);
  assign bus.line_addr     = line_addr_q;
  assign busy              = (state_q == FILL) || (state_q == WRITE);
  assign done              = (state_q == DONE);
  assign accept            = bus.host_valid && (state_q == FILL);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    line_addr_d = line_addr_q;
    clear       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = num_lines;
          clear  = 1'b1;
          state_d = (num_lines == 16'd0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (accept && last_word) begin
          line_addr_d = addr_q;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + PCW'(STEP);
        rem_d   = rem_q - 16'd1;
        clear   = 1'b1;
        state_d = (rem_q == 16'd1) ? DONE : FILL;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      line_addr_q <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      line_addr_q <= line_addr_d;
      rem_q       <= rem_d;
    end
  end

  line_packer #(
    .HOSTW (HOSTW),
    .WORDS (WORDS)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .accept    (accept),
    .word_in   (bus.host_data),
    .line_out  (bus.line_data),
    .last_word (last_word)
  );

endmodule

// File: tb/tb_instr_line_loader.sv
// Directed bench for instr_line_loader: hand-computed write cycles, addresses and lines.
module tb_instr_line_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_lines = '0;
  logic        busy, done;

  instr_line_loader_if #(.PCW(32), .INW(512), .HOSTW(64)) bus_if ();

  instr_line_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_lines (num_lines),
    .busy      (busy),
    .done      (done),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int           nw;
  int           done_cyc;
  int           words_taken;
  logic         busy_at1;
  logic         busy_at_done;
  int           wr_cyc  [0:7];
  logic [31:0]  wr_addr [0:7];
  logic [511:0] wr_data [0:7];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] exp_line(input logic [31:0] seed, input int i);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[j*64 +: 64] = 64'(seed + 32'(i*8 + j));
    return r;
  endfunction

  // Runs one load; the host offers an incrementing word stream starting at seed.
  // bubble=1 presents a word only on even cycles after start.
  task automatic run_load(input logic [31:0] base, input logic [15:0] n, input bit bubble,
                          input logic [31:0] seed, input int spur_k, input int max_cyc);
    logic [31:0] wval;
    wval = seed;
    nw = 0;
    done_cyc = -1;
    busy_at1 = 1'bx;
    busy_at_done = 1'bx;
    start = 1'b1;
    base_addr = base;
    num_lines = n;
    bus_if.host_valid = 1'b0;
    tick();
    base_addr = 32'hDEAD_BEEF;
    num_lines = 16'd7;
    for (int k = 1; k <= max_cyc; k++) begin
      start = (k == spur_k);
      bus_if.host_valid = bubble ? ((k % 2) == 0) : 1'b1;
      bus_if.host_data  = 64'(wval);
      #1;
      if (k == 1) busy_at1 = busy;
      if (bus_if.line_write_en) begin
        chk("ready_in_write", {511'd0, bus_if.host_ready}, 512'd0);
        if (nw < 8) begin
          wr_cyc[nw]  = k;
          wr_addr[nw] = bus_if.line_addr;
          wr_data[nw] = bus_if.line_data;
        end
        $display("line write %0d at cycle %0d addr %08h word0 %016h", nw, k,
                 bus_if.line_addr, bus_if.line_data[63:0]);
        nw++;
      end
      if (bus_if.host_ready && bus_if.host_valid) wval++;
      if (done) begin
        done_cyc = k;
        busy_at_done = busy;
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    bus_if.host_valid = 1'b0;
    words_taken = int'(wval - seed);
    if (done_cyc < 0) chk("load_timeout", 512'd0, 512'd1);
    tick();
  endtask

  initial begin
    bus_if.host_valid = 1'b0;
    bus_if.host_data  = '0;

    // Reset state
    #12;
    chk("rst_ready", {511'd0, bus_if.host_ready}, 512'd0);
    chk("rst_wen",   {511'd0, bus_if.line_write_en}, 512'd0);
    chk("rst_data",  bus_if.line_data, 512'd0);
    chk("rst_addr",  {480'd0, bus_if.line_addr}, 512'd0);
    chk("rst_busy",  {511'd0, busy}, 512'd0);
    chk("rst_done",  {511'd0, done}, 512'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-FILL after three words
    start = 1'b1; base_addr = 32'h80; num_lines = 16'd2;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus_if.host_valid = 1'b1;
      bus_if.host_data  = 64'(i * 32'h11);
      tick();
    end
    bus_if.host_valid = 1'b0;
    chk("partial_line", {320'd0, bus_if.line_data[191:0]}, {320'd0, 64'h33, 64'h22, 64'h11});
    chk("partial_busy", {511'd0, busy}, 512'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {511'd0, bus_if.host_ready}, 512'd0);
    chk("arst_data",  bus_if.line_data, 512'd0);
    chk("arst_busy",  {511'd0, busy}, 512'd0);
    #1 rst_n = 1'b1;
    tick();
    run_load(32'h0, 16'd1, 1'b0, 32'h100, 0, 40);
    chk("post_rst_nw",   512'(nw), 512'd1);
    chk("post_rst_addr", {480'd0, wr_addr[0]}, 512'd0);
    chk("post_rst_line", wr_data[0], exp_line(32'h100, 0));

    // Single line at 0x40, words 0..7
    run_load(32'h40, 16'd1, 1'b0, 32'h0, 0, 40);
    chk("single_cyc",  512'(wr_cyc[0]), 512'd9);
    chk("single_addr", {480'd0, wr_addr[0]}, 512'h40);
    chk("single_lo",   {448'd0, wr_data[0][63:0]}, 512'd0);
    chk("single_hi",   {448'd0, wr_data[0][511:448]}, 512'd7);
    chk("single_done", 512'(done_cyc), 512'd10);
    chk("single_busy1", {511'd0, busy_at1}, 512'd1);

    // Three lines, continuous stream
    run_load(32'h0, 16'd3, 1'b0, 32'h1000, 0, 60);
    chk("three_nw", 512'(nw), 512'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("three_cyc%0d", i),  512'(wr_cyc[i]), 512'(9 * (i + 1)));
      chk($sformatf("three_addr%0d", i), {480'd0, wr_addr[i]}, 512'(32'h20 * i));
      chk($sformatf("three_line%0d", i), wr_data[i], exp_line(32'h1000, i));
    end
    chk("three_done", 512'(done_cyc), 512'd28);
    chk("three_busy_at_done", {511'd0, busy_at_done}, 512'd0);

    // Host bubbles: valid only on even cycles
    run_load(32'h200, 16'd2, 1'b1, 32'h2000, 0, 80);
    chk("bub_nw",    512'(nw), 512'd2);
    chk("bub_cyc0",  512'(wr_cyc[0]), 512'd17);
    chk("bub_cyc1",  512'(wr_cyc[1]), 512'd33);
    chk("bub_line0", wr_data[0], exp_line(32'h2000, 0));
    chk("bub_line1", wr_data[1], exp_line(32'h2000, 1));
    chk("bub_words", 512'(words_taken), 512'd16);
    chk("bub_done",  512'(done_cyc), 512'd34);

    // Zero-line load
    run_load(32'h300, 16'd0, 1'b0, 32'h3000, 0, 10);
    chk("zero_done",  512'(done_cyc), 512'd1);
    chk("zero_nw",    512'(nw), 512'd0);
    chk("zero_busy",  {511'd0, busy_at1}, 512'd0);
    chk("zero_words", 512'(words_taken), 512'd0);

    // Start pulse during FILL is ignored
    run_load(32'h100, 16'd1, 1'b0, 32'h4000, 4, 40);
    chk("spur_nw",   512'(nw), 512'd1);
    chk("spur_cyc",  512'(wr_cyc[0]), 512'd9);
    chk("spur_addr", {480'd0, wr_addr[0]}, 512'h100);
    chk("spur_line", wr_data[0], exp_line(32'h4000, 0));
    chk("spur_done", 512'(done_cyc), 512'd10);
    tick();
    chk("spur_idle_busy", {511'd0, busy}, 512'd0);

    // Address wrap
    run_load(32'hFFFF_FFE0, 16'd2, 1'b0, 32'h5000, 0, 40);
    chk("wrap_addr0", {480'd0, wr_addr[0]}, 512'hFFFF_FFE0);
    chk("wrap_addr1", {480'd0, wr_addr[1]}, 512'd0);
    chk("wrap_line1", wr_data[1], exp_line(32'h5000, 1));
    chk("wrap_done",  512'(done_cyc), 512'd19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_line_loader.md
# instr_line_loader

Loads a program image from the host-side word stream into the instruction cache before and between kernel runs. Accepts HOSTW-bit words over a valid/ready handshake and packs them into INW-bit cache lines. Issues one single-cycle line write per completed line with the matching instruction-address, and holds the fetch stage stalled until the whole image is written. It is the write-side driver of the cache's line-write port (`instr_write_en` / `instr_in`).

## Interface
- PCW, 32, width of instruction addresses (PC units = one INSTRW instruction)
- INSTRW, 16, instruction width in bits
- INW, 512, cache line width in bits
- HOSTW, 64, host stream word width; INW must be a multiple of HOSTW
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a load, sampled only in IDLE
- base_addr  input  PCW  PC of first instruction in the image; must be multiple of INW/INSTRW (32)
- num_lines  input  16  number of lines to load; 0 is legal
- host_valid  input  1  host_data holds a word
- host_data  input  HOSTW  stream word
- host_ready  output  1  loader accepts the word this cycle
- line_write_en  output  1  one-cycle line write strobe to instruction cache
- line_data  output  INW  packed line, valid when line_write_en=1
- line_addr  output  PCW  PC of line's first instruction, valid when line_write_en=1
- busy  output  1  load in progress; drives fetch stall
- done  output  1  one-cycle pulse when last line is written (or zero-line load completes)

## Operation
- WORDS = INW/HOSTW (8); LINE_STEP = INW/INSTRW (32).
- States: IDLE, FILL, WRITE, DONE.
- IDLE: host_ready=0, busy=0. start=1 → latch base_addr into addr register and num_lines into remaining counter. If num_lines=0 → DONE, else → FILL with word count 0.
- FILL: host_ready=1, busy=1. On host_valid&&host_ready, word k goes to line_data[k*HOSTW +: HOSTW] (first word = least-significant). The word count then increments. Acceptance of word WORDS-1 → WRITE.
- WRITE: host_ready=0, line_write_en=1, line_addr=addr register. Next edge: addr += LINE_STEP (mod 2^PCW) and remaining −= 1. If remaining becomes 0 → DONE, else → FILL with word count cleared.
- DONE: done=1, busy=0, host_ready=0 → IDLE.
- start outside IDLE is ignored; inputs latched at start are not re-sampled mid-load.
- Host words presented in IDLE, WRITE or DONE are not accepted (host_ready=0); the host must hold them.
- Reset (any state, any time): → IDLE and the partial line is discarded. Outputs go to 0 asynchronously: host_ready, line_write_en, line_data, line_addr, busy and done all reset to 0.
- line_data and line_addr hold their last values outside WRITE. They are meaningful only under line_write_en.

## Timing
- All outputs are registered or decoded from the state register only. No combinational path from host_valid to host_ready.
- With host_valid held high: start at cycle t, words accepted t+1..t+8, line_write_en at t+9. Each subsequent line takes 9 cycles, so the last write is at t+9N and done is at t+9N+1.
- num_lines=0: done at t+1, no line_write_en.
- Host bubbles stretch FILL cycle-for-cycle; there is no timeout.
- busy is high from t+1 through the last WRITE cycle inclusive.
- addr wraps modulo 2^PCW without error.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE, FILL, WRITE, DONE), localparams WORDS_PER_LINE and LINE_STEP, derived word-count width $clog2(WORDS_PER_LINE).
- One sub-module `line_packer`: word counter plus indexed line register. It has ports clear, accept, word in, line out, and last_word.
- The top holds the FSM, addr register and remaining counter.

## Test plan
- Reset mid-FILL after 3 words → all outputs 0 immediately. A fresh start with base_addr=0, num_lines=1 then produces one write at PC 0 with no leftover words.
- Single line: base_addr=0x40, num_lines=1, words 0x0..0x7 back-to-back → line_write_en at start+9, line_addr=0x40, line_data[63:0]=0 and [511:448]=7, done at start+10.
- Three lines, continuous stream → writes at start+9/18/27 with addr 0x0/0x20/0x40, done at start+28, busy low the same cycle.
- host_valid toggling 1-0 per cycle → each line takes 17 cycles, no word lost or duplicated (check with incrementing pattern), host_ready=0 during WRITE.
- num_lines=0 → done at start+1, line_write_en never asserted. A start pulse during FILL of a normal load has no effect.
- Wrap: base_addr=0xFFFFFFE0, num_lines=2 → second write at line_addr=0x0.
